// File: rtl/branch_resolve_queue.sv
// ============================================================================
// branch_resolve_queue
//
// This is an in-order queue of in-flight branch predictions. Each entry holds
// {PC, predicted direction} until the actual outcome of the oldest entry
// arrives. For every resolution the block sends a one-cycle registered update
// back to the predictor's training port. A mispredict discards every younger
// entry, because those entries were fetched down the wrong path. The block
// also keeps saturating accuracy counters.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   pred_valid     new prediction presented
//   pred_pc        PC of the predicted branch
//   pred_taken     predicted direction (1 = taken)
//   pred_ready     queue accepts a prediction this cycle (combinational)
//   res_valid      outcome of the oldest entry presented
//   res_taken      actual direction of the oldest entry
//   upd_valid      registered update pulse to the predictor
//   upd_pc         PC of the resolved branch
//   upd_taken      actual outcome of the resolved branch
//   upd_mispredict resolved prediction was wrong
//   flush          pulse: younger entries discarded
//   occupancy      current entry count
//   resolved_cnt   total resolutions, saturating
//   correct_cnt    correct resolutions, saturating
//   err_underflow  sticky: res_valid arrived while the queue was empty
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH_LOG2 = 3,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_valid,
    input  logic [PC_WIDTH-1:0]   pred_pc,
    input  logic                  pred_taken,
    output logic                  pred_ready,
    input  logic                  res_valid,
    input  logic                  res_taken,
    output logic                  upd_valid,
    output logic [PC_WIDTH-1:0]   upd_pc,
    output logic                  upd_taken,
    output logic                  upd_mispredict,
    output logic                  flush,
    output logic [DEPTH_LOG2:0]   occupancy,
    output logic [CNT_WIDTH-1:0]  resolved_cnt,
    output logic [CNT_WIDTH-1:0]  correct_cnt,
    output logic                  err_underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Entry storage. This is pure data, so it carries no reset.
    logic [PC_WIDTH-1:0]   pc_mem [DEPTH];
    logic [DEPTH-1:0]      taken_mem;

    logic [DEPTH_LOG2-1:0] head, tail;
    logic [DEPTH_LOG2:0]   occ;

    logic                  running;
    logic                  enq_ok;
    logic                  res_ok;
    logic                  underflow;
    logic                  head_taken;
    logic [PC_WIDTH-1:0]   head_pc;
    logic                  mis;
    logic                  push;

    // Registered update stage
    logic                  vld_p1;
    logic                  flush_p1;
    logic [PC_WIDTH-1:0]   upd_pc_p1;
    logic                  upd_taken_p1;
    logic                  upd_mis_p1;

    logic [CNT_WIDTH-1:0]  resolved_q;
    logic [CNT_WIDTH-1:0]  correct_q;
    logic                  err_q;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. RECOVER always lasts exactly one cycle.
    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_RUN:     state_nxt = mis ? ST_RECOVER : ST_RUN;
            ST_RECOVER: state_nxt = ST_RUN;
            default:    state_nxt = ST_RUN;
        endcase
    end

    // FSM: outputs. A full queue refuses new work even if it pops this cycle.
    always_comb begin
        running    = 1'b0;
        pred_ready = 1'b0;
        case (state)
            ST_RUN: begin
                running    = 1'b1;
                pred_ready = (occ != FULL_CNT);
            end
            default: begin
                running    = 1'b0;
                pred_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request decode (resolve stage, cycle N)
    // ------------------------------------------------------------------
    always_comb begin
        head_pc    = pc_mem[head];
        head_taken = taken_mem[head];
        enq_ok     = pred_valid && pred_ready;
        res_ok     = res_valid && running && (occ != '0);
        underflow  = res_valid && running && (occ == '0);
        mis        = res_ok && (res_taken != head_taken);
        // An enqueue that coincides with a mispredict is wrong-path work, so it is dropped.
        push       = enq_ok && !mis;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= pred_pc;
            taken_mem[tail] <= pred_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (mis) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= tail + DEPTH_LOG2'(1);
            end
            if (res_ok) begin
                head <= head + DEPTH_LOG2'(1);
            end
            case ({push, res_ok})
                2'b10:   occ <= occ + (DEPTH_LOG2 + 1)'(1);
                2'b01:   occ <= occ - (DEPTH_LOG2 + 1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Update stage (visible after edge N+1)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            flush_p1     <= 1'b0;
            upd_pc_p1    <= '0;
            upd_taken_p1 <= 1'b0;
            upd_mis_p1   <= 1'b0;
            resolved_q   <= '0;
            correct_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            vld_p1   <= res_ok;
            flush_p1 <= mis;
            if (res_ok) begin
                upd_pc_p1    <= head_pc;
                upd_taken_p1 <= res_taken;
                upd_mis_p1   <= mis;
                resolved_q   <= sat_inc(resolved_q);
                if (!mis) begin
                    correct_q <= sat_inc(correct_q);
                end
            end
            if (underflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign upd_valid      = vld_p1;
    assign flush          = flush_p1;
    assign upd_pc         = upd_pc_p1;
    assign upd_taken      = upd_taken_p1;
    assign upd_mispredict = upd_mis_p1;
    assign occupancy      = occ;
    assign resolved_cnt   = resolved_q;
    assign correct_cnt    = correct_q;
    assign err_underflow  = err_q;

endmodule

// File: tb/tb_branch_resolve_queue.sv
module tb_branch_resolve_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pred_valid = 1'b0;
    logic [31:0] pred_pc = '0;
    logic        pred_taken = 1'b0;
    logic        res_valid = 1'b0;
    logic        res_taken = 1'b0;

    logic        pred_ready, upd_valid, upd_taken, upd_mispredict, flush, err_underflow;
    logic [31:0] upd_pc;
    logic [3:0]  occupancy;
    logic [31:0] resolved_cnt, correct_cnt;

    logic        pred_ready4, upd_valid4, upd_taken4, upd_mispredict4, flush4, err_underflow4;
    logic [31:0] upd_pc4;
    logic [3:0]  occupancy4;
    logic [3:0]  resolved_cnt4, correct_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH_LOG2(3), .PC_WIDTH(32), .CNT_WIDTH(32)) u_dut (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .flush(flush), .occupancy(occupancy),
        .resolved_cnt(resolved_cnt), .correct_cnt(correct_cnt), .err_underflow(err_underflow)
    );

    // Narrow-counter instance on the same stimulus, so the counters saturate early.
    branch_resolve_queue #(.DEPTH_LOG2(3), .PC_WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready4),
        .res_valid(res_valid), .res_taken(res_taken),
        .upd_valid(upd_valid4), .upd_pc(upd_pc4), .upd_taken(upd_taken4), .upd_mispredict(upd_mispredict4),
        .flush(flush4), .occupancy(occupancy4),
        .resolved_cnt(resolved_cnt4), .correct_cnt(correct_cnt4), .err_underflow(err_underflow4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [32:0] mq[$];   // {pc, predicted taken}, oldest first
    bit          m_recover = 0;
    bit          m_upd_valid = 0, m_upd_taken = 0, m_upd_mis = 0, m_flush = 0, m_err = 0;
    logic [31:0] m_upd_pc = '0;
    int          m_res = 0, m_cor = 0;

    always @(posedge clk or posedge reset) begin : model
        bit          run_ok, enq_ok, mis;
        logic [32:0] e;
        if (reset) begin
            mq.delete();
            m_recover   <= 0;
            m_upd_valid <= 0;
            m_upd_taken <= 0;
            m_upd_mis   <= 0;
            m_flush     <= 0;
            m_err       <= 0;
            m_upd_pc    <= '0;
            m_res       <= 0;
            m_cor       <= 0;
        end else begin
            run_ok = !m_recover;
            enq_ok = pred_valid && run_ok && (mq.size() < 8);
            mis    = 0;
            m_upd_valid <= 0;
            m_flush     <= 0;
            if (res_valid && run_ok && mq.size() == 0) m_err <= 1;
            if (res_valid && run_ok && mq.size() > 0) begin
                e = mq.pop_front();
                mis = (e[0] != res_taken);
                m_upd_valid <= 1;
                m_upd_pc    <= e[32:1];
                m_upd_taken <= res_taken;
                m_upd_mis   <= mis;
                m_res       <= m_res + 1;
                if (!mis) m_cor <= m_cor + 1;
            end
            if (mis) begin
                mq.delete();
                m_flush <= 1;
            end else if (enq_ok) begin
                mq.push_back({pred_pc, pred_taken});
            end
            m_recover <= mis;
        end
    end

    function automatic int sat4(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    always @(negedge clk) begin
        chk("pred_ready", pred_ready, (!m_recover && mq.size() != 8));
        chk("occupancy", occupancy, mq.size());
        chk("upd_valid", upd_valid, m_upd_valid);
        chk("upd_pc", upd_pc, m_upd_pc);
        chk("upd_taken", upd_taken, m_upd_taken);
        chk("upd_mispredict", upd_mispredict, m_upd_mis);
        chk("flush", flush, m_flush);
        chk("err_underflow", err_underflow, m_err);
        chk("resolved_cnt", resolved_cnt, m_res);
        chk("correct_cnt", correct_cnt, m_cor);
        chk("upd_valid4", upd_valid4, m_upd_valid);
        chk("occupancy4", occupancy4, mq.size());
        chk("resolved_cnt4", resolved_cnt4, sat4(m_res));
        chk("correct_cnt4", correct_cnt4, sat4(m_cor));
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit pv, input logic [31:0] pc, input bit pt, input bit rv, input bit rt);
        @(negedge clk);
        pred_valid = pv;
        pred_pc    = pc;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int k, r;
        #1 reset = 1'b1;
        repeat (2) idle();
        chk("rst_pred_ready", pred_ready, 1);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_resolved", resolved_cnt, 0);
        reset = 1'b0;

        // Test 1: three correct in-order resolutions
        drive(1, 32'h100, 1, 0, 0);
        drive(1, 32'h104, 1, 0, 0);
        drive(1, 32'h108, 1, 0, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 1);
        chk("t1_upd_pc0", upd_pc, 32'h100);
        chk("t1_upd_valid0", upd_valid, 1);
        drive(0, 0, 0, 1, 1);
        chk("t1_upd_pc1", upd_pc, 32'h104);
        idle();
        chk("t1_upd_pc2", upd_pc, 32'h108);
        chk("t1_resolved", resolved_cnt, 3);
        chk("t1_correct", correct_cnt, 3);
        chk("t1_occupancy", occupancy, 0);
        idle();
        chk("t1_upd_valid_off", upd_valid, 0);

        // Test 2: fill, full-refusal with pop, wraparound
        for (k = 0; k < 8; k++) drive(1, 32'h400 + 4 * k, k[0], 0, 0);
        idle();
        chk("t2_occ_full", occupancy, 8);
        chk("t2_ready_full", pred_ready, 0);
        drive(1, 32'h420, 1'b0, 1, 1'b0);   // refused enqueue, pops 0x400
        idle();
        chk("t2_occ_after_pop", occupancy, 7);
        chk("t2_upd_pc_first", upd_pc, 32'h400);
        r = 1;
        while (k < 20) begin
            drive(1, 32'h400 + 4 * k, k[0], 1, r[0]);
            k++;
            r++;
        end
        while (r < 20) begin
            drive(0, 0, 0, 1, r[0]);
            r++;
        end
        idle();
        chk("t2_last_pc", upd_pc, 32'h44C);
        chk("t2_occ_empty", occupancy, 0);
        chk("t2_resolved", resolved_cnt, 23);

        // Test 3: mispredict flushes younger entries
        drive(1, 32'h200, 1, 0, 0);
        drive(1, 32'h204, 1, 0, 0);
        drive(1, 32'h208, 0, 0, 0);
        drive(1, 32'h20C, 1, 1, 0);          // mispredict plus wrong-path enqueue
        drive(0, 0, 0, 1, 1);                // res_valid during RECOVER, ignored
        chk("t3_upd_mis", upd_mispredict, 1);
        chk("t3_flush", flush, 1);
        chk("t3_upd_pc", upd_pc, 32'h200);
        chk("t3_occ", occupancy, 0);
        chk("t3_ready_recover", pred_ready, 0);
        chk("t3_resolved", resolved_cnt, 24);
        chk("t3_correct", correct_cnt, 23);
        idle();
        chk("t3_ready_back", pred_ready, 1);
        chk("t3_flush_off", flush, 0);
        chk("t3_no_err", err_underflow, 0);
        chk("t3_occ_dropped", occupancy, 0);

        // Test 4: underflow with simultaneous enqueue
        drive(1, 32'h300, 1, 1, 1);
        idle();
        chk("t4_err", err_underflow, 1);
        chk("t4_no_upd", upd_valid, 0);
        chk("t4_occ", occupancy, 1);
        drive(0, 0, 0, 1, 1);
        idle();
        chk("t4_upd_pc", upd_pc, 32'h300);
        chk("t4_err_sticky", err_underflow, 1);

        // Test 5: 21 more correct resolves; narrow counters stay saturated
        drive(1, 32'h500, 1, 0, 0);
        for (int i = 0; i < 20; i++) drive(1, 32'h504 + 4 * i, 1, 1, 1);
        drive(0, 0, 0, 1, 1);
        idle();
        chk("t5_res4_sat", resolved_cnt4, 4'hF);
        chk("t5_cor4_sat", correct_cnt4, 4'hF);
        chk("t5_resolved", resolved_cnt, 46);
        chk("t5_correct", correct_cnt, 45);

        // Test 6: reset mid-stream with an update pending
        for (int i = 0; i < 5; i++) drive(1, 32'h600 + 4 * i, 1, 0, 0);
        drive(0, 0, 0, 1, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        res_valid = 1'b0;
        #1;
        chk("t6_upd_valid", upd_valid, 0);
        chk("t6_flush", flush, 0);
        chk("t6_occ", occupancy, 0);
        chk("t6_ready", pred_ready, 1);
        chk("t6_resolved", resolved_cnt, 0);
        chk("t6_correct4", correct_cnt4, 0);
        chk("t6_err", err_underflow, 0);
        chk("t6_upd_pc", upd_pc, 0);
        repeat (2) idle();
        reset = 1'b0;
        repeat (3) idle();
        chk("t6_upd_valid_after", upd_valid, 0);
        chk("t6_flush_after", flush, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
